// File: rtl/lsu_mem_interface_pkg.sv
// Shared encodings for the load/store unit: funct3 size/sign codes and FSM states.
package lsu_mem_interface_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/lsu_mem_interface_lane_align.sv
// Byte-lane steering for the LSU: byte enables, store replication, load extract/extend
// and the alignment/legal-funct3 check. Purely combinational, no backpressure.
module lsu_lane_align
  import lsu_mem_interface_pkg::*;
(
  input  logic        i_req_valid,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_bus_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata_rep,
  output logic [31:0] o_load_ext,
  output logic        o_misaligned
);

  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_bad;

  assign w_shift = i_bus_rdata >> {i_addr_lo, 3'b000};
  assign w_byte  = w_shift[7:0];
  assign w_half  = i_addr_lo[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];

  always_comb begin
    o_be        = 4'b0000;
    o_wdata_rep = 32'h0;
    o_load_ext  = 32'h0;
    w_bad       = 1'b0;
    case (i_funct3)
      F3_B, F3_BU: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata_rep = {4{i_wdata[7:0]}};
        o_load_ext  = {{24{w_byte[7] & ~i_funct3[2]}}, w_byte};
      end
      F3_H, F3_HU: begin
        o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_wdata_rep = {2{i_wdata[15:0]}};
        o_load_ext  = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
        w_bad       = i_addr_lo[0];
      end
      F3_W: begin
        o_be        = 4'b1111;
        o_wdata_rep = i_wdata;
        o_load_ext  = i_bus_rdata;
        w_bad       = (i_addr_lo != 2'b00);
      end
      default: w_bad = 1'b1;
    endcase
  end

  assign o_misaligned = i_req_valid & w_bad;

endmodule

// File: rtl/lsu_mem_interface.sv
// Load/store unit: one registered request/ready bus transaction per access, stalling the core
// through IDLE-request and WAIT (min 3 cycles incl. DONE); aborts with bus_err after TIMEOUT_CYCLES.
module lsu_mem_interface
  import lsu_mem_interface_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ready,
  input  logic [31:0] bus_rdata
);

  localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [3:0]  r_bus_be;
  logic [31:0] r_bus_wdata;
  logic [31:0] r_rdata;
  logic        r_bus_err;

  logic [3:0]  w_be;
  logic [31:0] w_wdata_rep;
  logic [31:0] w_load_ext;
  logic        w_misaligned;
  logic        w_start;
  logic        w_timeout;

  lsu_lane_align u_lane_align (
    .i_req_valid  (req_valid),
    .i_funct3     (funct3),
    .i_addr_lo    (addr[1:0]),
    .i_wdata      (wdata),
    .i_bus_rdata  (bus_rdata),
    .o_be         (w_be),
    .o_wdata_rep  (w_wdata_rep),
    .o_load_ext   (w_load_ext),
    .o_misaligned (w_misaligned)
  );

  assign w_start   = (r_state == ST_IDLE) & req_valid & ~w_misaligned;
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == LP_CNT_LAST);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_WAIT;
      ST_WAIT: if (bus_ready || w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= 32'h0;
      r_rdata     <= 32'h0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= req_write;
            r_bus_addr  <= {addr[31:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata_rep;
            r_cnt       <= '0;
          end
        end
        ST_WAIT: begin
          // addr/funct3 are held by the stalled core, so the lane extract is still valid here
          if (bus_ready) begin
            r_bus_req <= 1'b0;
            r_rdata   <= r_bus_we ? 32'h0 : w_load_ext;
            r_bus_err <= 1'b0;
          end else if (w_timeout) begin
            r_bus_req <= 1'b0;
            r_rdata   <= 32'h0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: r_bus_err <= 1'b0;
        default: r_bus_req <= 1'b0;
      endcase
    end
  end

  // Gated by rst_n so a held req_valid cannot keep the core frozen during reset.
  assign stall      = rst_n & (w_start | (r_state == ST_WAIT));
  assign misaligned = w_misaligned;
  assign rdata      = r_rdata;
  assign bus_err    = r_bus_err;
  assign bus_req    = r_bus_req;
  assign bus_we     = r_bus_we;
  assign bus_addr   = r_bus_addr;
  assign bus_be     = r_bus_be;
  assign bus_wdata  = r_bus_wdata;

endmodule

// File: doc/lsu_mem_interface.md
Name: lsu_mem_interface

Overview:
- Load/store unit directly downstream of the ALU. It takes the ALU result as the effective address, the rs2 value as store data, and funct3 as size/sign.
- Runs one word-aligned request/ready transaction on the data bus, stalls the single-cycle core until it completes, and returns the sign- or zero-extended load result to the writeback mux.
- Detects misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT_CYCLES, 16: WAIT cycles before abort with bus_err; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  core clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  current instruction is a load/store; held stable while stall=1
- req_write  input  1  1=store, 0=load
- funct3  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- addr  input  32  effective address (ALU result)
- wdata  input  32  store data (rs2)
- stall  output  1  freeze PC/regfile write this cycle
- rdata  output  32  extended load result, valid while state=DONE
- misaligned  output  1  combinational: request misaligned or funct3 illegal
- bus_err  output  1  high during DONE when the transaction timed out
- bus_req  output  1  registered bus request
- bus_we  output  1  registered write enable
- bus_addr  output  32  registered, {addr[31:2],2'b00}
- bus_be  output  4  registered byte enables
- bus_wdata  output  32  registered lane-replicated store data
- bus_ready  input  1  bus accepted/completed; read data valid same cycle
- bus_rdata  input  32  bus read word

Behaviour:
- Reset (async, rst_n=0): state=IDLE; bus_req, bus_we, bus_be, bus_addr, bus_wdata, rdata, bus_err, counter all 0. Asserting reset mid-transaction drops bus_req immediately and abandons the transaction.
- misaligned=1 when req_valid and any of:
  - funct3 in {011,110,111}
  - half access with addr[0]=1
  - word access with addr[1:0]!=0
  - Effect: no bus access, stall=0, state stays IDLE.
- stall = (IDLE & req_valid & ~misaligned) | WAIT. stall is 0 in DONE.
- FSM transitions:
  - IDLE -> WAIT: on req_valid & ~misaligned. Registers bus_req=1, bus_we, bus_addr, bus_be, bus_wdata. Clears the counter.
  - WAIT -> DONE: on bus_ready. Drops bus_req. Captures the extended load (0 for stores) into rdata. bus_err stays 0.
  - WAIT -> DONE: on counter==TIMEOUT_CYCLES-1 without bus_ready (only when TIMEOUT_CYCLES!=0). Drops bus_req. rdata=0, bus_err=1.
  - WAIT, otherwise: counter increments.
  - DONE -> IDLE: unconditional. The core advances during DONE; bus_err clears on leaving DONE.
- Latency: minimum 3 cycles per access (IDLE request, WAIT with bus_ready, DONE). Each extra WAIT cycle adds 1.
- bus_ready while in IDLE or DONE is ignored.
- Back-to-back memory instructions: DONE forces a return to IDLE, so the next request starts one cycle later.
- Byte enables:
  - b: 4'b0001<<addr[1:0]
  - h: 4'b0011 (addr[1]=0) or 4'b1100 (addr[1]=1)
  - w: 4'b1111
- Store data: b = {4{wdata[7:0]}}; h = {2{wdata[15:0]}}; w = wdata.
- Load extraction: byte lane addr[1:0] or half lane addr[1] selected from bus_rdata.
  - b and h: sign-extend.
  - bu and hu: zero-extend.
  - w: pass through.

Decomposition:
- Shared package: funct3 size/sign encodings; state encodings IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
- One natural sub-module, lsu_lane_align (combinational): produces be/wdata replication, load extraction/extension, and the misaligned check. The FSM and timeout counter stay in the top.

Test Plan:
1. Word store, addr=0x0000_1004, wdata=0xDEADBEEF, bus_ready on the first WAIT cycle -> bus_addr=0x1004, bus_be=1111, bus_wdata=0xDEADBEEF, bus_we=1; stall high for exactly 2 cycles.
2. lb at addr=0x...03, bus_rdata=0x80AA_BBCC -> rdata=0xFFFF_FF80. Same access as lbu -> 0x0000_0080.
3. sh at addr=0x...02, wdata=0x1234_5678 -> bus_be=1100, bus_wdata=0x5678_5678. lhu at addr=0x...02 with bus_rdata=0xF00D_0000 -> rdata=0x0000_F00D.
4. lw at addr=0x...01 -> misaligned=1, stall=0, bus_req never asserts. funct3=011 -> misaligned=1.
5. TIMEOUT_CYCLES=16, bus_ready held low -> bus_req high for 16 cycles, then DONE with bus_err=1, rdata=0, stall=0, and IDLE on the next cycle.
6. rst_n asserted during WAIT with bus_req=1 -> bus_req, stall, and bus outputs go 0 without waiting for a clock edge. After release, a new lw completes normally.
